// File: rtl/slow_pulse_domain_crosser.sv
// Synchronises a slow-domain level pulse, queues its rising edges and replays them as paced
// single-cycle pulses. Define SLOW_PULSE_OVERFLOW_EN to enable the sticky overflow flag.
module slow_pulse_domain_crosser #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PENDING = 15,
    parameter int GAP         = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulseIn,
    input  logic       ready,
    output logic       pulseOut,
    output logic [7:0] pending,
    output logic       overflow
);
    localparam logic [7:0] MAX_LEVEL = 8'(MAX_PENDING);
    localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, EMIT, HOLDOFF} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] valid_q, valid_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic [7:0]             pending_q, pending_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic                   sync_out;
    logic                   detect;
    logic                   dequeue;
    logic                   at_limit;

    // valid_q tracks which sync stages hold real post-reset samples; edges are only armed
    // once the synchronised input has genuinely been seen low.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], pulseIn};
        valid_d  = {valid_q[SYNC_STAGES-2:0], 1'b1};
        prev_d   = sync_out;
        armed_d  = armed_q | (valid_q[SYNC_STAGES-1] & ~sync_out);
        detect   = armed_q & sync_out & ~prev_q;
    end

    always_comb begin
        dequeue   = (state_q == IDLE) && (pending_q != 8'd0) && ready;
        at_limit  = (pending_q == MAX_LEVEL);
        pending_d = pending_q;
        if (detect && !dequeue) begin
            if (!at_limit) begin
                pending_d = pending_q + 8'd1;
            end
        end else if (!detect && dequeue) begin
            pending_d = pending_q - 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            valid_q   <= '0;
            prev_q    <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= 8'd0;
            gap_cnt_q <= 8'd0;
        end else begin
            sync_q    <= sync_d;
            valid_q   <= valid_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (dequeue) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (GAP > 0) begin
                    state_d   = HOLDOFF;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulseOut = (state_q == EMIT);
        pending  = pending_q;
    end

`ifdef SLOW_PULSE_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (detect & ~dequeue & at_limit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_slow_pulse_domain_crosser.sv
// Bench for slow_pulse_domain_crosser: three parameterisations share one stimulus stream and are
// checked every cycle against a timestamp-based event model, plus vector tables and corner cases.
module tb_slow_pulse_domain_crosser;
    logic       clock = 1'b0;
    logic       reset;
    logic       pulseIn;
    logic       ready;
    logic       pOut[3];
    logic [7:0] pend[3];
    logic       ov[3];

    int checks = 0;
    int errors = 0;

    int mS[3];
    int mM[3];
    int mG[3];
    int mPend[3];
    int mNextFree[3];
    int mArrive[3];
    logic mOv[3];
    logic mExpPulse[3];
    int mEdge;
    logic mLastSamp;

    int pulseCnt[3];
    int lastEdge[3];
    int minSpacing[3];
    int maxSpacing[3];

    typedef struct {
        logic       p;
        logic       r;
        logic       expPulse;
        logic [7:0] expPend;
    } vec_t;
    vec_t vecs[12];

    always #5 clock = ~clock;

    slow_pulse_domain_crosser dut0 (
        .clock(clock), .reset(reset), .pulseIn(pulseIn), .ready(ready),
        .pulseOut(pOut[0]), .pending(pend[0]), .overflow(ov[0])
    );
    slow_pulse_domain_crosser #(.SYNC_STAGES(2), .MAX_PENDING(3), .GAP(0)) dut1 (
        .clock(clock), .reset(reset), .pulseIn(pulseIn), .ready(ready),
        .pulseOut(pOut[1]), .pending(pend[1]), .overflow(ov[1])
    );
    slow_pulse_domain_crosser #(.SYNC_STAGES(3), .MAX_PENDING(15), .GAP(4)) dut2 (
        .clock(clock), .reset(reset), .pulseIn(pulseIn), .ready(ready),
        .pulseOut(pOut[2]), .pending(pend[2]), .overflow(ov[2])
    );

    function automatic logic expOv(input logic m);
`ifdef SLOW_PULSE_OVERFLOW_EN
        return m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic modelClear();
        mEdge     = 0;
        mLastSamp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mPend[i]     = 0;
            mNextFree[i] = 0;
            mArrive[i]   = -1;
            mOv[i]       = 1'b0;
            mExpPulse[i] = 1'b0;
        end
    endtask

    // Each post-reset 0->1 step in the sampled input (never the very first sample) becomes
    // pending SYNC_STAGES edges later; an emission blocks the next one for GAP+2 edges.
    task automatic modelEdge();
        logic samp;
        logic rdy;
        logic ev;
        logic deq;
        samp = pulseIn;
        rdy  = ready;
        mEdge++;
        for (int i = 0; i < 3; i++) begin
            ev = (mArrive[i] == mEdge);
            if (ev) mArrive[i] = -1;
            deq = rdy && (mPend[i] > 0) && (mEdge >= mNextFree[i]);
            mExpPulse[i] = deq;
            if (deq) mNextFree[i] = mEdge + mG[i] + 2;
            if (ev && !deq && mPend[i] == mM[i]) mOv[i] = 1'b1;
            else mPend[i] = mPend[i] + (ev ? 1 : 0) - (deq ? 1 : 0);
        end
        if (mEdge >= 2 && samp && !mLastSamp) begin
            for (int i = 0; i < 3; i++) mArrive[i] = mEdge + mS[i];
        end
        mLastSamp = samp;
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_pulse%0d@%0d", i, mEdge), pOut[i], mExpPulse[i]);
            check($sformatf("model_pend%0d@%0d", i, mEdge), pend[i], mPend[i]);
            check($sformatf("model_ovf%0d@%0d", i, mEdge), ov[i], expOv(mOv[i]));
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 3; i++) begin
            pulseCnt[i]   = 0;
            lastEdge[i]   = 0;
            minSpacing[i] = 1000000;
            maxSpacing[i] = 0;
        end
    endtask

    task automatic applyStimulus(input logic p, input logic r);
        pulseIn = p;
        ready   = r;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            if (pOut[i] === 1'b1) begin
                if (pulseCnt[i] > 0) begin
                    if (mEdge - lastEdge[i] < minSpacing[i]) minSpacing[i] = mEdge - lastEdge[i];
                    if (mEdge - lastEdge[i] > maxSpacing[i]) maxSpacing[i] = mEdge - lastEdge[i];
                end
                lastEdge[i] = mEdge;
                pulseCnt[i]++;
            end
        end
    endtask

    // Asserted away from the clock edge so the asynchronous clear is observed on its own.
    task automatic doReset(input logic p);
        reset   = 1'b1;
        pulseIn = p;
        ready   = 1'b0;
        modelClear();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_pulse%0d", i), pOut[i], 1'b0);
            check($sformatf("rst_pend%0d", i), pend[i], 8'd0);
            check($sformatf("rst_ovf%0d", i), ov[i], 1'b0);
        end
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelClear();
    endtask

    task automatic pulses(input int n, input logic r);
        for (int k = 0; k < n; k++) begin
            repeat (6) applyStimulus(1'b1, r);
            repeat (6) applyStimulus(1'b0, r);
        end
    endtask

    initial begin
        logic lvl;
        logic r;
        int   remain;
        int   mode;
        bit   seen;

        mS = '{2, 2, 3};
        mM = '{15, 3, 15};
        mG = '{0, 0, 4};
        clearCounts();

        for (int j = 0; j < 12; j++) begin
            vecs[j].p        = (j < 10);
            vecs[j].r        = 1'b1;
            vecs[j].expPulse = (j == 3);
            vecs[j].expPend  = (j == 2) ? 8'd1 : 8'd0;
        end

        // Single long pulse: latency and width.
        doReset(1'b0);
        repeat (5) applyStimulus(1'b0, 1'b1);
        for (int j = 0; j < 12; j++) begin
            applyStimulus(vecs[j].p, vecs[j].r);
            check($sformatf("tbl_pulse[%0d]", j), pOut[0], vecs[j].expPulse);
            check($sformatf("tbl_pend[%0d]", j), pend[0], vecs[j].expPend);
        end

        // Five queued pulses, then drain; MAX_PENDING=3 instance saturates.
        doReset(1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        clearCounts();
        pulses(5, 1'b0);
        check("queued_no_pulse", pulseCnt[0], 0);
        check("queued_pend0", pend[0], 8'd5);
        check("queued_pend1_sat", pend[1], 8'd3);
        check("queued_pend2", pend[2], 8'd5);
        check("queued_ovf1", ov[1], expOv(1'b1));
        check("queued_ovf0", ov[0], 1'b0);
        clearCounts();
        repeat (40) applyStimulus(1'b0, 1'b1);
        check("drain_cnt0", pulseCnt[0], 5);
        check("drain_spacing_min0", minSpacing[0], 2);
        check("drain_spacing_max0", maxSpacing[0], 2);
        check("drain_cnt1", pulseCnt[1], 3);
        check("drain_cnt2", pulseCnt[2], 5);
        check("drain_spacing_min2", minSpacing[2], 6);
        check("drain_spacing_max2", maxSpacing[2], 6);
        check("drain_pend0", pend[0], 8'd0);
        check("drain_ovf1_sticky", ov[1], expOv(1'b1));

        // GAP=4 with two queued events.
        doReset(1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        pulses(2, 1'b0);
        check("gap_pend2", pend[2], 8'd2);
        clearCounts();
        repeat (20) applyStimulus(1'b0, 1'b1);
        check("gap_cnt2", pulseCnt[2], 2);
        check("gap_spacing2", maxSpacing[2], 6);

        // Detect coincident with dequeue at pending=1.
        doReset(1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        pulses(1, 1'b0);
        check("coinc_pend_before", pend[0], 8'd1);
        clearCounts();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        check("coinc_pulse", pOut[0], 1'b1);
        check("coinc_pend", pend[0], 8'd1);
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b1);
        check("coinc_cnt0", pulseCnt[0], 2);

        // Reset during EMIT, pulseIn held high across release.
        doReset(1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        pulses(3, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            applyStimulus(1'b0, 1'b1);
            seen = (pOut[0] === 1'b1);
        end
        check("emit_wait_timeout", seen, 1'b1);
        doReset(1'b1);
        clearCounts();
        repeat (10) applyStimulus(1'b1, 1'b1);
        check("no_pulse_after_release", pulseCnt[0], 0);
        check("no_pend_after_release", pend[0], 8'd0);
        repeat (6) applyStimulus(1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        check("fresh_edge_cnt0", pulseCnt[0], 1);

        // Randomised phases (>= 4 cycles) and ready modes, with one mid-run reset.
        doReset(1'b0);
        lvl    = 1'b0;
        remain = $urandom_range(4, 12);
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) doReset(lvl);
            if (remain == 0) begin
                lvl    = ~lvl;
                remain = $urandom_range(4, 12);
            end
            remain--;
            mode = (c / 40) % 3;
            if (mode == 0) r = 1'b0;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            applyStimulus(lvl, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slow_pulse_domain_crosser.md
SLOW_PULSE_DOMAIN_CROSSER -- requirements
Module: slow_pulse_domain_crosser

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pulseIn; legal range 2..4.
REQ-002 Parameter MAX_PENDING, default 15, saturation limit of the pending-event counter; legal range 1..255.
REQ-003 Parameter GAP, default 0, idle clock cycles forced between consecutive pulseOut assertions; legal range 0..255.
REQ-004 clock  input  1  destination (fast) clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pulseIn  input  1  level pulse from the slower domain, asynchronous to clock.
REQ-007 ready  input  1  downstream may accept a pulse.
REQ-008 pulseOut  output  1  single-clock pulse, one per detected pulseIn rising edge.
REQ-009 pending  output  8  events detected but not yet emitted.
REQ-010 overflow  output  1  sticky flag: an event was dropped at saturation.

Function
REQ-011 pulseIn SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage SHALL be used by downstream logic.
REQ-012 An event SHALL be detected when the last sync stage is 1 and a registered copy of it is 0 (rising edge); falling edges SHALL be ignored.
REQ-013 pulseIn high and low phases shorter than SYNC_STAGES+1 clock periods SHALL be outside the contract (events may be lost).
REQ-014 FSM states: IDLE, EMIT, HOLDOFF.
REQ-015 IDLE -> EMIT when pending > 0 and ready = 1; the same edge SHALL decrement pending.
REQ-016 pulseOut SHALL be 1 exactly while in EMIT (registered, glitch-free).
REQ-017 EMIT -> HOLDOFF if GAP > 0, else EMIT -> IDLE; ready SHALL be ignored outside IDLE.
REQ-018 HOLDOFF SHALL last exactly GAP cycles, then -> IDLE.
REQ-019 Detected event with pending < MAX_PENDING SHALL increment pending.
REQ-020 Simultaneous detect and dequeue SHALL leave pending unchanged.
REQ-021 Detect while pending = MAX_PENDING and no dequeue SHALL drop the event; pending SHALL stay at MAX_PENDING.
REQ-022 Latency: idle, ready = 1, pending = 0, pulseOut SHALL assert in the cycle following the (SYNC_STAGES+2)th rising edge counted from the first edge sampling pulseIn = 1.
REQ-023 Back-to-back emission with GAP = 0 SHALL produce pulseOut high one cycle, low at least one cycle (EMIT -> IDLE -> EMIT).
REQ-024 Upper pending bits above the MAX_PENDING width SHALL read 0.

Reset
REQ-025 Reset SHALL asynchronously clear sync chain, edge register, pending, GAP counter, overflow, and force IDLE.
REQ-026 During and after reset: pulseOut = 0, pending = 0, overflow = 0.
REQ-027 Reset asserted mid-EMIT SHALL terminate pulseOut immediately; queued events SHALL be discarded.
REQ-028 pulseIn high at reset release SHALL NOT generate an event (edge register clears to 0 and sync chain refills, but first rising edge is suppressed until last stage has been observed 0).

Configuration
REQ-029 Macro SLOW_PULSE_OVERFLOW_EN defined: overflow SHALL set on the drop condition of REQ-021 and hold until reset.
REQ-030 Macro SLOW_PULSE_OVERFLOW_EN undefined: overflow port SHALL remain present, tied to 0; drop behaviour of REQ-021 unchanged.

Verification
REQ-031 Defaults, ready = 1, pulseIn 0->1 held 10 cycles -> one pulseOut, 1 cycle wide, asserted after 4th rising edge; pending returns to 0.
REQ-032 ready = 0, 5 pulseIn pulses (6 high/6 low cycles each) -> pending = 5, no pulseOut; ready = 1 -> 5 pulseOut, GAP = 0 spacing 1 low cycle, pending 5,4,3,2,1,0.
REQ-033 MAX_PENDING = 3, ready = 0, 5 pulses -> pending = 3, overflow = 1 with SLOW_PULSE_OVERFLOW_EN, 0 without; ready = 1 -> exactly 3 pulseOut.
REQ-034 GAP = 4, pending = 2, ready = 1 -> pulseOut at cycle t and t+6 only.
REQ-035 Reset asserted during EMIT with pending = 3 -> pulseOut falls same cycle, pending = 0; pulseIn held high across release -> no pulseOut until a fresh 0->1.
REQ-036 Event detect coincident with IDLE->EMIT dequeue at pending = 1 -> pending stays 1, second pulseOut follows.
